// File: rtl/i2c_bus_arbiter.sv
// Round-robin, request-locked arbiter sharing one I2C master among NUM_REQ controllers.
// Ports: clk_in/rst (sync, active-high); req_in/gnt_out/owner_out/busy_out handshake;
//   req_*_in command slices in, req_*_out responses to owner; i2c_* to/from the master.
//   Optional `I2C_ARB_TIMEOUT_EN adds an idle watchdog and the timeout_out pulse port.
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int OWNER_W        = 3,
  parameter int TIMEOUT_CYCLES = 96000000
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_in,
  output logic [NUM_REQ-1:0]     gnt_out,
  output logic [OWNER_W-1:0]     owner_out,
  output logic                   busy_out,
  input  logic [NUM_REQ-1:0]     req_en_in,
  input  logic [NUM_REQ-1:0]     req_rd_wr_in,
  input  logic [NUM_REQ-1:0]     req_continuous_in,
  input  logic [7*NUM_REQ-1:0]   req_address_in,
  input  logic [6*NUM_REQ-1:0]   req_data_bytes_in,
  input  logic [8*NUM_REQ-1:0]   req_wr_data_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  output logic [NUM_REQ-1:0]     req_wr_valid_out,
  output logic [NUM_REQ-1:0]     req_rd_valid_out,
  output logic [7:0]             req_rd_data_out,
  input  logic                   i2c_ready_in,
  input  logic                   i2c_wr_valid_in,
  input  logic                   i2c_rd_valid_in,
  input  logic [7:0]             i2c_rd_data_in,
  output logic                   i2c_en,
  output logic                   i2c_rd_wr,
  output logic                   i2c_continuous,
  output logic [6:0]             i2c_address,
  output logic [5:0]             i2c_data_bytes,
  output logic [7:0]             i2c_wr_data
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_out
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** OWNER_W) < NUM_REQ ||
      TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("i2c_bus_arbiter: illegal parameter set");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q;
  logic [OWNER_W-1:0]   last_q;
  logic [OWNER_W-1:0]   pick;
  logic                 found;
  int                   idx;
  logic [NUM_REQ-1:0]   req_sh;
  logic [NUM_REQ-1:0]   onehot;
  logic                 own_req;
  logic                 tmo_hit;
  logic [7*NUM_REQ-1:0] addr_sh;
  logic [6*NUM_REQ-1:0] db_sh;
  logic [8*NUM_REQ-1:0] wd_sh;

  assign onehot  = NUM_REQ'(1) << owner_q;
  assign own_req = |(req_in & onehot);
  assign addr_sh = req_address_in >> (7 * int'(owner_q));
  assign db_sh   = req_data_bytes_in >> (6 * int'(owner_q));
  assign wd_sh   = req_wr_data_in >> (8 * int'(owner_q));

  // First pending requester scanning upward from last_owner+1.
  always_comb begin
    pick   = '0;
    found  = 1'b0;
    idx    = 0;
    req_sh = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx    = (int'(last_q) + i) % NUM_REQ;
      req_sh = req_in >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        pick  = OWNER_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OWNER_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == OWNED)
        owner_q <= pick;
      if (state_q == OWNED && state_d == IDLE)
        last_q <= owner_q;
    end
  end

  // Release waits for ready so an in-flight transfer is never cut off.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found && i2c_ready_in) state_d = OWNED;
      OWNED:   if ((!own_req && i2c_ready_in) || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_out          = '0;
    owner_out        = '0;
    busy_out         = 1'b0;
    i2c_en           = 1'b0;
    i2c_rd_wr        = 1'b0;
    i2c_continuous   = 1'b0;
    i2c_address      = '0;
    i2c_data_bytes   = '0;
    i2c_wr_data      = '0;
    req_ready_out    = '0;
    req_wr_valid_out = '0;
    req_rd_valid_out = '0;
    req_rd_data_out  = '0;
    if (state_q == OWNED) begin
      gnt_out          = onehot;
      owner_out        = owner_q;
      busy_out         = 1'b1;
      i2c_en           = |(req_en_in & onehot) & own_req;
      i2c_rd_wr        = |(req_rd_wr_in & onehot);
      i2c_continuous   = |(req_continuous_in & onehot);
      i2c_address      = addr_sh[6:0];
      i2c_data_bytes   = db_sh[5:0];
      i2c_wr_data      = wd_sh[7:0];
      req_ready_out    = i2c_ready_in ? onehot : '0;
      req_wr_valid_out = i2c_wr_valid_in ? onehot : '0;
      req_rd_valid_out = i2c_rd_valid_in ? onehot : '0;
      req_rd_data_out  = i2c_rd_data_in;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] idle_cnt;
  logic             idle_tick;

  // Owner holds the bus with nothing to send while the master is free.
  assign idle_tick = (state_q == OWNED) && i2c_ready_in && !i2c_en;
  assign tmo_hit   = idle_tick && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      idle_cnt    <= '0;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= tmo_hit;
      if (!idle_tick || tmo_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule
